// File: rtl/axi_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_ram_slave
//   AXI burst responder backed by a word-organised RAM. One write burst and
//   one read burst may be in flight at the same time, each on its own FSM.
//   FIXED, INCR and WRAP bursts of 1..16 beats are supported.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW*                  : write address channel (ID, ADDR, LEN, SIZE, BURST)
//   S_AXI_W*                   : write data channel (DATA, STRB, LAST)
//   S_AXI_B*                   : write response (ID, RESP)
//   S_AXI_AR*                  : read address channel
//   S_AXI_R*                   : read data channel (ID, DATA, RESP, LAST)
// ---------------------------------------------------------------------------
module axi_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [31:0]             S_AXI_AWADDR,
    input  logic [3:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [31:0]             S_AXI_ARADDR,
    input  logic [3:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int          IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Address of the following beat. WRAP keeps the bits above the
    // (LEN+1)*4-byte block and lets only the in-block offset roll over.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [3:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + 32'd4) & mask);
            default: next_addr = a + 32'd4;
        endcase
    endfunction

    // Burst attributes this RAM cannot honour.
    function automatic logic cfg_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [3:0] len);
        cfg_err = (size != 3'b010) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic logic oob(input logic [31:0] a);
        oob = (a[31:2] >= DEPTH_W);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write side ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [31:0]           waddr_q, waddr_d;
    logic [3:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  mem_we;
    logic                  w_oob;
    logic                  w_final;

    assign w_oob   = oob(waddr_q);
    assign w_final = (wcnt_q == wlen_q);

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // Also raises AWREADY one cycle after reset or after a B handshake.
                awready_d = 1'b1;
                if (S_AXI_AWVALID && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wid_d     = S_AXI_AWID;
                    waddr_d   = S_AXI_AWADDR;
                    wlen_d    = S_AXI_AWLEN;
                    wburst_d  = S_AXI_AWBURST;
                    wcnt_d    = 4'd0;
                    werr_d    = cfg_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID && wready_q) begin
                    if (w_oob) werr_d = 1'b1;
                    else       mem_we = 1'b1;
                    if (S_AXI_WLAST != w_final) werr_d = 1'b1;
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    // Beat count alone closes the burst; WLAST only feeds the error flag.
                    if (w_final) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_d ? SLVERR : OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wid_q     <= '0;
            waddr_q   <= 32'd0;
            wlen_q    <= 4'd0;
            wburst_q  <= 2'b00;
            wcnt_q    <= 4'd0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
        end
    end

    // RAM is never cleared. A same-cycle read of the written word sees the
    // old contents because the read side samples before this update lands.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[waddr_q[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [31:0]           raddr_q, raddr_d;   // address of the next beat to fetch
    logic [3:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [3:0]            rcnt_q, rcnt_d;
    logic                  rcfg_q, rcfg_d;
    logic [31:0]           rd_addr;
    logic                  rd_oob;
    logic [DATA_WIDTH-1:0] rd_word;

    // In IDLE the fetch address comes straight from AR so beat 0 is
    // registered on the handshake edge.
    assign rd_addr = (r_state_q == R_IDLE) ? S_AXI_ARADDR : raddr_q;
    assign rd_oob  = oob(rd_addr);
    assign rd_word = rd_oob ? '0 : mem[rd_addr[IDX_W+1:2]];

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rcfg_d    = rcfg_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    rid_d     = S_AXI_ARID;
                    rlen_d    = S_AXI_ARLEN;
                    rburst_d  = S_AXI_ARBURST;
                    rcfg_d    = cfg_err(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN);
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rresp_d   = (rcfg_d || rd_oob) ? SLVERR : OKAY;
                    rlast_d   = (S_AXI_ARLEN == 4'd0);
                    rcnt_d    = 4'd0;
                    raddr_d   = next_addr(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = OKAY;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d = rd_word;
                        rresp_d = (rcfg_q || rd_oob) ? SLVERR : OKAY;
                        rlast_d = ((rcnt_q + 4'd1) == rlen_q);
                        rcnt_d  = rcnt_q + 4'd1;
                        raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= 32'd0;
            rlen_q    <= 4'd0;
            rburst_q  <= 2'b00;
            rcnt_q    <= 4'd0;
            rcfg_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rcfg_q    <= rcfg_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = wid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;

endmodule
